// File: rtl/fourier_transform_pkg.sv
// fourier_transform_pkg: shared constants, FSM state type and Q1.15 twiddle
// tables for the 16-point sequential DFT.
package fourier_transform_pkg;

    localparam int FFT_LENGTH = 16;
    localparam int LOG2_N     = 4;
    localparam int ACC_W      = 36;                 // MAC accumulator width
    localparam int TW_W       = 16;                 // Q1.15 twiddle width
    localparam int OUT_SHIFT  = 15 + LOG2_N;        // Q-format + 1/N scaling

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // cos(2*pi*m/16) and sin(2*pi*m/16) in Q1.15, rounded to nearest.
    // +1.0 is not representable and saturates to 32767; -1.0 is exact.
    localparam logic signed [TW_W-1:0] COS_TAB [0:15] = '{
        16'sh7FFF, 16'sh7642, 16'sh5A82, 16'sh30FC,
        16'sh0000, 16'shCF04, 16'shA57E, 16'sh89BE,
        16'sh8000, 16'sh89BE, 16'shA57E, 16'shCF04,
        16'sh0000, 16'sh30FC, 16'sh5A82, 16'sh7642
    };

    localparam logic signed [TW_W-1:0] SIN_TAB [0:15] = '{
        16'sh0000, 16'sh30FC, 16'sh5A82, 16'sh7642,
        16'sh7FFF, 16'sh7642, 16'sh5A82, 16'sh30FC,
        16'sh0000, 16'shCF04, 16'shA57E, 16'sh89BE,
        16'sh8000, 16'sh89BE, 16'shA57E, 16'shCF04
    };

endpackage

// File: rtl/fourier_transform_dft_cmac.sv
// dft_cmac: real sample times complex twiddle, product registered once, then
// accumulated. 'first' marks the first term of a bin: the accumulator loads
// the product instead of adding, which clears it per bin without a bubble.
//   aclk, aresetn   clock, async active-low reset
//   in_vld, first   operand valid / first term of a bin
//   x, c, s         sample and cos/sin twiddle
//   acc_re, acc_im  re += x*c, im -= x*s
module dft_cmac
    import fourier_transform_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     in_vld,
    input  logic                     first,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [TW_W-1:0]   c,
    input  logic signed [TW_W-1:0]   s,
    output logic signed [ACC_W-1:0]  acc_re,
    output logic signed [ACC_W-1:0]  acc_im
);

    localparam int PROD_W = DATA_W + TW_W;

    logic signed [PROD_W-1:0] prod_re, prod_im;
    logic                     vld_q, first_q;
    logic signed [ACC_W-1:0]  ext_re, ext_im;

    assign ext_re = {{(ACC_W-PROD_W){prod_re[PROD_W-1]}}, prod_re};
    assign ext_im = {{(ACC_W-PROD_W){prod_im[PROD_W-1]}}, prod_im};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prod_re <= '0;
            prod_im <= '0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            acc_re  <= '0;
            acc_im  <= '0;
        end else begin
            vld_q   <= in_vld;
            first_q <= first;
            if (in_vld) begin
                prod_re <= x * c;
                prod_im <= x * s;
            end
            if (vld_q) begin
                acc_re <= first_q ? ext_re : acc_re + ext_re;
                acc_im <= first_q ? -ext_im : acc_im - ext_im;
            end
        end
    end

endmodule

// File: rtl/fourier_transform.sv
// fourier_transform: 16-point DFT over a stream of real samples.
// Collects a frame, runs 256 sequential complex MACs, then streams the 16
// bins out with AXI-Stream handshaking.
//   aclk, aresetn          clock, async active-low reset
//   S_AXIS_filter_*        input samples (no backpressure)
//   M_AXIS_fft_*           output bins {imag, real}, tlast on bin 15
module fourier_transform
    import fourier_transform_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int FFT_LENGTH       = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_filter_tdata,
    input  logic                          S_AXIS_filter_tvalid,
    output logic [2*AXIS_TDATA_WIDTH-1:0] M_AXIS_fft_tdata,
    output logic                          M_AXIS_fft_tvalid,
    output logic                          M_AXIS_fft_tlast,
    input  logic                          M_AXIS_fft_tready
);

    localparam int W  = AXIS_TDATA_WIDTH;
    localparam int IW = $clog2(FFT_LENGTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(FFT_LENGTH - 1);

    state_t  state, state_nxt;
    logic [IW-1:0] cnt, k, n, ob;
    logic          mac_busy;               // issuing MAC operands
    logic [2:0]    vld_pipe;               // [0] issue, [1] product, [2] acc
    logic [2:1]    last_pipe;
    logic [2:1][IW-1:0] bin_pipe;
    logic          bin_wr;

    logic signed [W-1:0]     x_mem   [FFT_LENGTH];
    logic        [2*W-1:0]   res_mem [FFT_LENGTH];
    logic        [2*IW-1:0]  kn;
    logic signed [ACC_W-1:0] acc_re, acc_im;
    logic                    unused_bits;

    assign kn          = k * n;
    assign vld_pipe[0] = (state == COMPUTE) && mac_busy;
    assign bin_wr      = vld_pipe[2] && last_pipe[2];

    dft_cmac #(.DATA_W(W)) u_cmac (
        .aclk    (aclk),
        .aresetn (aresetn),
        .in_vld  (vld_pipe[0]),
        .first   (n == '0),
        .x       (x_mem[n]),
        .c       (COS_TAB[kn[IW-1:0]]),
        .s       (SIN_TAB[kn[IW-1:0]]),
        .acc_re  (acc_re),
        .acc_im  (acc_im)
    );

    // acc >>> OUT_SHIFT keeping the low W bits is just a bit slice.
    assign unused_bits = ^{acc_re[ACC_W-1], acc_re[OUT_SHIFT-1:0],
                           acc_im[ACC_W-1], acc_im[OUT_SHIFT-1:0], kn[2*IW-1:IW]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= COLLECT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (S_AXIS_filter_tvalid && cnt == LAST_IDX) state_nxt = COMPUTE;
            COMPUTE: if (bin_wr && bin_pipe[2] == LAST_IDX)     state_nxt = EMIT;
            EMIT:    if (M_AXIS_fft_tvalid && M_AXIS_fft_tready && ob == LAST_IDX)
                         state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Buffers carry no reset.
    always_ff @(posedge aclk) begin
        if (state == COLLECT && S_AXIS_filter_tvalid) x_mem[cnt] <= S_AXIS_filter_tdata;
        if (bin_wr) res_mem[bin_pipe[2]] <= {acc_im[OUT_SHIFT +: W], acc_re[OUT_SHIFT +: W]};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt               <= '0;
            k                 <= '0;
            n                 <= '0;
            ob                <= '0;
            mac_busy          <= 1'b0;
            vld_pipe[2:1]     <= '0;
            last_pipe         <= '0;
            bin_pipe          <= '0;
            M_AXIS_fft_tvalid <= 1'b0;
            M_AXIS_fft_tlast  <= 1'b0;
            M_AXIS_fft_tdata  <= '0;
        end else begin
            vld_pipe[2:1] <= vld_pipe[1:0];
            last_pipe     <= {last_pipe[1], n == LAST_IDX};
            bin_pipe      <= {bin_pipe[1], k};
            case (state)
                COLLECT: begin
                    if (S_AXIS_filter_tvalid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            mac_busy <= 1'b1;
                            k        <= '0;
                            n        <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    if (mac_busy) begin
                        n <= n + 1'b1;
                        if (n == LAST_IDX) begin
                            k <= k + 1'b1;
                            if (k == LAST_IDX) mac_busy <= 1'b0;
                        end
                    end
                    // Bin 15 lands in res_mem on this same edge; bin 0 was
                    // written long ago, so it can be presented right away.
                    if (state_nxt == EMIT) begin
                        M_AXIS_fft_tvalid <= 1'b1;
                        M_AXIS_fft_tlast  <= 1'b0;
                        M_AXIS_fft_tdata  <= res_mem[0];
                        ob                <= '0;
                    end
                end
                EMIT: begin
                    if (M_AXIS_fft_tvalid && M_AXIS_fft_tready) begin
                        if (ob == LAST_IDX) begin
                            M_AXIS_fft_tvalid <= 1'b0;
                            M_AXIS_fft_tlast  <= 1'b0;
                            cnt               <= '0;
                        end else begin
                            ob               <= ob + 1'b1;
                            M_AXIS_fft_tdata <= res_mem[ob + 1'b1];
                            M_AXIS_fft_tlast <= (ob == LAST_IDX - 1'b1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fourier_transform.sv
module tb_fourier_transform;
    localparam int W = 16;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [W-1:0]   s_tdata = '0;
    logic           s_tvalid = 1'b0;
    logic [2*W-1:0] m_tdata;
    logic           m_tvalid, m_tlast;
    logic           m_tready = 1'b1;

    int total = 0;
    int bad   = 0;
    int frame   [16];
    int got_re  [16];
    int got_im  [16];
    int got_last[16];
    int lat;

    always #5 aclk = ~aclk;

    fourier_transform #(.AXIS_TDATA_WIDTH(W), .FFT_LENGTH(16)) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .S_AXIS_filter_tdata  (s_tdata),
        .S_AXIS_filter_tvalid (s_tvalid),
        .M_AXIS_fft_tdata     (m_tdata),
        .M_AXIS_fft_tvalid    (m_tvalid),
        .M_AXIS_fft_tlast     (m_tlast),
        .M_AXIS_fft_tready    (m_tready)
    );

    task automatic check(input string tag, input int got, input int exp, input int tol = 0);
        total++;
        if (got < exp - tol || got > exp + tol) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
        end
    endtask

    // Drives frame[] on 16 consecutive edges; returns #1 after the edge that
    // accepted sample 15. keep_vld leaves tvalid high with a garbage value.
    task automatic send_frame(input bit keep_vld, input int garbage);
        for (int i = 0; i < 16; i++) begin
            s_tdata  = W'(frame[i]);
            s_tvalid = 1'b1;
            @(posedge aclk); #1;
        end
        s_tdata  = W'(garbage);
        s_tvalid = keep_vld;
    endtask

    task automatic wait_first(output int cyc);
        cyc = 0;
        while (!m_tvalid && cyc < 400) begin
            @(posedge aclk); #1;
            cyc++;
        end
    endtask

    // Receives 16 bins; holds tready low for stall_len cycles on stall_bin,
    // expecting the held beat to be {0, hold_re}.
    task automatic recv(input int stall_bin, input int stall_len, input int hold_re);
        int idx = 0;
        int stall = 0;
        int guard = 0;
        while (idx < 16 && guard < 1000) begin
            m_tready = !(idx == stall_bin && stall < stall_len);
            if (!m_tready) begin
                check("stall_vld", int'(m_tvalid), 1);
                check("stall_re", int'($signed(m_tdata[15:0])), hold_re);
                check("stall_im", int'($signed(m_tdata[31:16])), 0);
                check("stall_last", int'(m_tlast), 0);
                stall++;
            end else if (m_tvalid) begin
                got_re[idx]   = int'($signed(m_tdata[15:0]));
                got_im[idx]   = int'($signed(m_tdata[31:16]));
                got_last[idx] = int'(m_tlast);
                idx++;
            end
            @(posedge aclk); #1;
            guard++;
        end
        m_tready = 1'b1;
        check("recv_count", idx, 16);
        check("post_emit_vld", int'(m_tvalid), 0);
    endtask

    task automatic check_impulse(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_re%0d", tag, i), got_re[i], 99);
            check($sformatf("%s_im%0d", tag, i), got_im[i], 0);
            check($sformatf("%s_last%0d", tag, i), got_last[i], (i == 15) ? 1 : 0);
        end
    endtask

    task automatic load_impulse();
        for (int i = 0; i < 16; i++) frame[i] = (i == 0) ? 1600 : 0;
    endtask

    initial begin
        int cos_tab[16];
        int seen;
        cos_tab = '{16000, 14782, 11314, 6123, 0, -6123, -11314, -14782,
                    -16000, -14782, -11314, -6123, 0, 6123, 11314, 14782};

        // reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_vld", int'(m_tvalid), 0);
        check("rst_last", int'(m_tlast), 0);
        check("rst_data", int'(m_tdata), 0);
        aresetn = 1'b1;

        // impulse, tready always high
        load_impulse();
        send_frame(1'b0, 0);
        wait_first(lat);
        check("imp_latency", lat, 258);
        recv(-1, 0, 0);
        check_impulse("imp");
        check("hold_data", int'($signed(m_tdata[15:0])), 99);
        check("hold_last", int'(m_tlast), 0);

        // DC
        for (int i = 0; i < 16; i++) frame[i] = 100;
        send_frame(1'b0, 0);
        wait_first(lat);
        check("dc_latency", lat, 258);
        recv(-1, 0, 0);
        check("dc_re0", got_re[0], 99);
        check("dc_im0", got_im[0], 0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("dc_re%0d", i), got_re[i], 0, 1);
            check($sformatf("dc_im%0d", i), got_im[i], 0, 1);
        end

        // cosine at bin 1
        for (int i = 0; i < 16; i++) frame[i] = cos_tab[i];
        send_frame(1'b0, 0);
        wait_first(lat);
        recv(-1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("cos_re%0d", i), got_re[i], (i == 1 || i == 15) ? 8000 : 0, 2);
            check($sformatf("cos_im%0d", i), got_im[i], 0, 2);
        end

        // continuous tvalid with garbage outside COLLECT, stall on bin 3
        load_impulse();
        send_frame(1'b1, 7777);
        wait_first(lat);
        check("bp_latency", lat, 258);
        recv(3, 5, 99);
        check_impulse("bp");
        load_impulse();
        send_frame(1'b0, 0);
        wait_first(lat);
        check("next_latency", lat, 258);
        recv(-1, 0, 0);
        check_impulse("next");

        // reset at cycle 100 of COMPUTE
        for (int i = 0; i < 16; i++) frame[i] = 100;
        send_frame(1'b0, 0);
        repeat (100) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        check("mid_rst_vld", int'(m_tvalid), 0);
        check("mid_rst_last", int'(m_tlast), 0);
        check("mid_rst_data", int'(m_tdata), 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge aclk); #1;
            if (m_tvalid) seen++;
        end
        check("mid_rst_no_bins", seen, 0);
        load_impulse();
        send_frame(1'b0, 0);
        wait_first(lat);
        check("rst_imp_latency", lat, 258);
        recv(-1, 0, 0);
        check_impulse("rst_imp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
